sram_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM (1-cycle read latency, write-through output, output held while en low) between two requesters, m0 and m1.
- m0 is the core data side; m1 is the DMA/debug side.
- Round-robin arbitration, one access per cycle.
- Optional post-reset clear engine zero-fills every entry before service starts.
- Sits between the requesters and the sram instance in the memory subsystem.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 33 +++
 rtl/sram_arbiter.sv | 119 +++++++++++
 tb/tb_sram_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM arbiter slice.
//   S_CLEAR / S_RUN : top-level FSM state encodings
//   M0 / M1         : requester ids (also the round-robin pointer values)
//   addr_w()        : address width for a given depth, never below 1
package sram_arb_pkg;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant.
//   clk, rst : clock, synchronous active-high reset (pointer -> M0)
//   req[1:0] : request vector, bit K = master K
//   accept   : grants allowed this cycle
//   gnt[1:0] : one-hot grant (or zero), same cycle as req
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // ptr names the master that wins the next contested cycle
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req == 2'b11) gnt = (ptr == M1) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Winner drops to lowest priority: after a grant to K, point at the other one
  always_ff @(posedge clk) begin
    if (rst)       ptr <= M0;
    else if (|gnt) ptr <= gnt[0] ? M1 : M0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between a
// core-side requester (m0) and a DMA/debug requester (m1), one access per
// cycle, round-robin on contention. An optional clear engine zero-fills the
// whole array after reset before any request is served.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   mK_req/we/addr/wdata  : requester K access (held until gnt)
//   mK_gnt_o              : access accepted this cycle (combinational)
//   mK_done_o, mK_rdata_o : response one cycle after grant
//   sram_*                : port to the SRAM instance
//   busy_o                : clear engine running, no grants
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int N_ENTRIES      = 128,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AW             = addr_w(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [AW-1:0]         m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_done_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [AW-1:0]         m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_done_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  busy_o
);

  localparam logic [AW-1:0] LAST = AW'(N_ENTRIES - 1);

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          owner;
  logic          resp_v;
  logic          run;
  logic          resp_live;
  logic [1:0]    gnt;

  // Gating with rst_i keeps grants and SRAM strobes quiet during the reset
  // cycle itself, not only from the cycle after.
  assign run = (state == S_RUN) && !rst_i;

  rr_arb2 u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({m1_req_i, m0_req_i}),
    .accept (run),
    .gnt    (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign busy_o   = (state == S_CLEAR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_cnt <= '0;
      owner   <= M0;
      resp_v  <= 1'b0;
    end else begin
      resp_v <= |gnt;
      if (|gnt) owner <= gnt[1];
      if (state == S_CLEAR) begin
        // Terminal compare on N_ENTRIES-1 so odd depths stop at the last row
        if (clr_cnt == LAST) begin
          state   <= S_RUN;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (!rst_i && state == S_CLEAR) begin
      sram_en_o   = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = clr_cnt;
    end else if (gnt[0]) begin
      sram_en_o    = 1'b1;
      sram_we_o    = m0_we_i;
      sram_addr_o  = m0_addr_i;
      sram_wdata_o = m0_wdata_i;
    end else if (gnt[1]) begin
      sram_en_o    = 1'b1;
      sram_we_o    = m1_we_i;
      sram_addr_o  = m1_addr_i;
      sram_wdata_o = m1_wdata_i;
    end
  end

  // A response pending when reset arrives is dropped, not delivered
  assign resp_live  = resp_v && !rst_i;
  assign m0_done_o  = resp_live && (owner == M0);
  assign m1_done_o  = resp_live && (owner == M1);
  assign m0_rdata_o = m0_done_o ? sram_rdata_i : '0;
  assign m1_rdata_o = m1_done_o ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int DW = 32;
  localparam int N  = 128;
  localparam int AW = 7;
  localparam int N2 = 5;
  localparam int AW2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_done, m1_gnt, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sram_en, sram_we, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  // second instance: odd depth, requests tied off, only the clear is observed
  logic           z1 = 1'b0;
  logic [AW2-1:0] za = '0;
  logic [DW-1:0]  zd = '0;
  logic           d2_g0, d2_d0, d2_g1, d2_d1, d2_en, d2_we, d2_busy;
  logic [DW-1:0]  d2_r0, d2_r1, d2_wdata;
  logic [AW2-1:0] d2_addr;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  sram_arbiter #(.DATA_WIDTH(DW), .N_ENTRIES(N), .CLEAR_ON_RESET(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_rdata_o(m1_rdata),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata), .busy_o(busy)
  );

  sram_arbiter #(.DATA_WIDTH(DW), .N_ENTRIES(N2), .CLEAR_ON_RESET(1)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(z1), .m0_we_i(z1), .m0_addr_i(za), .m0_wdata_i(zd),
    .m0_gnt_o(d2_g0), .m0_done_o(d2_d0), .m0_rdata_o(d2_r0),
    .m1_req_i(z1), .m1_we_i(z1), .m1_addr_i(za), .m1_wdata_i(zd),
    .m1_gnt_o(d2_g1), .m1_done_o(d2_d1), .m1_rdata_o(d2_r1),
    .sram_en_o(d2_en), .sram_we_o(d2_we), .sram_addr_o(d2_addr),
    .sram_wdata_o(d2_wdata), .sram_rdata_i(zd), .busy_o(d2_busy)
  );

  // behavioural single-port SRAM: write-through, output held while en low
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        sram_rdata     <= sram_wdata;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the expected response whenever a done pulse appears
  always @(negedge clk) begin
    #2;
    if (m0_done) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL m0 done: got unexpected pulse expected none");
      end else begin
        check("m0 rdata", m0_rdata, q0.pop_front());
        if (!m1_done) check("m1 rdata idle", m1_rdata, '0);
      end
    end
    if (m1_done) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL m1 done: got unexpected pulse expected none");
      end else begin
        check("m1 rdata", m1_rdata, q1.pop_front());
        if (!m0_done) check("m0 rdata idle", m0_rdata, '0);
      end
    end
  end

  // Drive one request, wait for its grant, queue the expected response.
  // Entered and left at a falling edge; the request is dropped on return.
  task automatic issue(input int p, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp, input int exp_wait);
    int   waits = 0;
    logic g;
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
    else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
    #1;
    g = (p == 0) ? m0_gnt : m1_gnt;
    while (!g && waits < 300) begin
      @(negedge clk); #1; waits++;
      g = (p == 0) ? m0_gnt : m1_gnt;
    end
    if (!g) begin
      tests++; fails++;
      $display("FAIL m%0d grant: got none after %0d cycles expected a grant", p, waits);
    end else begin
      check($sformatf("m%0d gnt wait", p), DW'(waits), DW'(exp_wait));
      check($sformatf("m%0d sram en/we", p), {30'd0, sram_en, sram_we}, {30'd0, 1'b1, we});
      check($sformatf("m%0d sram addr", p), DW'(sram_addr), DW'(addr));
      if (p == 0) q0.push_back(exp); else q1.push_back(exp);
    end
    @(negedge clk);
    if (p == 0) m0_req = 0; else m1_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset gnt/done", {28'd0, m0_gnt, m1_gnt, m0_done, m1_done}, '0);
    check("reset en/we", {30'd0, sram_en, sram_we}, '0);
    check("reset rdata", m0_rdata | m1_rdata, '0);
    check("reset busy", DW'(busy), 32'd1);
    rst = 0;
    #1;
    // clear sweep: one zero write per cycle, addresses 0..N-1, then RUN
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        check("clear busy", DW'(busy), 32'd1);
        check("clear en/we/wdata0", {29'd0, sram_en, sram_we, sram_wdata == '0}, 32'd7);
        check("clear addr", DW'(sram_addr), DW'(i));
      end else begin
        check("clear end busy", DW'(busy), 32'd0);
      end
      if (i < N2) check("odd clear addr", DW'(d2_addr), DW'(i));
      if (i <= N2) check("odd clear busy", DW'(d2_busy), (i < N2) ? 32'd1 : 32'd0);
      @(negedge clk); #1;
    end
    @(negedge clk);

    issue(0, 0, 7'd5, '0, 32'h0000_0000, 0);
    issue(0, 1, 7'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    issue(0, 0, 7'd3, '0, 32'hDEAD_BEEF, 0);
    // m1 writes @10 at t, m0 reads @10 at t+1 and must see the new word
    issue(1, 1, 7'd10, 32'h1234_5678, 32'h1234_5678, 0);
    issue(0, 0, 7'd10, '0, 32'h1234_5678, 0);
    #1;
    check("idle en/we", {30'd0, sram_en, sram_we}, '0);
    @(negedge clk);

    // contention: last grant went to m0, so order is m1,m0,m1,m0
    m0_req = 1; m0_we = 0; m0_addr = 7'd3;
    m1_req = 1; m1_we = 0; m1_addr = 7'd10;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k % 2 == 0) begin
        check("rr gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        q1.push_back(32'h1234_5678);
      end else begin
        check("rr gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        q0.push_back(32'hDEAD_BEEF);
      end
      @(negedge clk);
    end
    m0_req = 0; m1_req = 0;
    repeat (3) @(negedge clk);

    // reset in the cycle after an m1 grant: response dropped, clear restarts
    m1_req = 1; m1_we = 0; m1_addr = 7'd10;
    #1;
    check("pre-reset m1 gnt", DW'(m1_gnt), 32'd1);
    @(negedge clk);
    m1_req = 0; rst = 1;
    m0_req = 1; m0_we = 0; m0_addr = 7'd3;
    #1;
    check("reset-cycle m1 done", DW'(m1_done), 32'd0);
    check("reset-cycle m0 gnt", DW'(m0_gnt), 32'd0);
    @(negedge clk); #1;
    check("post-reset busy", DW'(busy), 32'd1);
    check("post-reset m1 done", DW'(m1_done), 32'd0);
    rst = 0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("reclear addr", DW'(sram_addr), DW'(i));
      check("reclear busy", DW'(busy), 32'd1);
      check("held m0 gnt", DW'(m0_gnt), 32'd0);
      @(negedge clk); #1;
    end
    check("first run m0 gnt", DW'(m0_gnt), 32'd1);
    check("first run busy", DW'(busy), 32'd0);
    if (m0_gnt) q0.push_back(32'h0000_0000);  // addr 3 was re-zeroed
    @(negedge clk);
    m0_req = 0;
    repeat (3) @(negedge clk);

    check("m0 responses drained", DW'(q0.size()), 32'd0);
    check("m1 responses drained", DW'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
